mcpu_bus_master: RTL and testbench

MCPU_BUS_MASTER -- requirements
Module: mcpu_bus_master

---
 rtl/system86_pkg.sv | 33 +++
 rtl/mbus_phase_gen.sv | 53 +++++
 rtl/mcpu_bus_master.sv | 89 ++++++++
 tb/tb_mcpu_bus_master.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/system86_pkg.sv
// Shared System 86 bus definitions: bus phase encoding, per-phase E/Q clock
// table and the address driven on MA while the bus is idle.
package system86_pkg;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_e;

  localparam logic [15:0] IDLE_ADDR_DEFAULT = 16'hFFFF;

  typedef struct packed {
    logic clk_1;  // Q
    logic clk_0;  // E
  } phase_clk_t;

  // Q rises at P1, E rises at P2, so Q leads E by exactly one phase.
  function automatic phase_clk_t phase_clk(input phase_e p);
    phase_clk_t c;
    c = '{clk_1: 1'b0, clk_0: 1'b0};
    case (p)
      P0:      c = '{clk_1: 1'b0, clk_0: 1'b0};
      P1:      c = '{clk_1: 1'b1, clk_0: 1'b0};
      P2:      c = '{clk_1: 1'b1, clk_0: 1'b1};
      P3:      c = '{clk_1: 1'b0, clk_0: 1'b1};
      default: c = '{clk_1: 1'b0, clk_0: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mbus_phase_gen.sv
// Bus phase sequencer: divides the master clock into four-phase bus cycles,
// decodes the E/Q phase clocks and flags the last clock of each cycle.
module mbus_phase_gen
  import system86_pkg::*;
#(
  parameter int PHASE_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] phase,
  output logic       clk_0,
  output logic       clk_1,
  output logic       cyc_end
);

  localparam logic [3:0] DIV_LAST = 4'(PHASE_DIV - 1);

  phase_e     phase_q, phase_d;
  logic [3:0] div_q, div_d;
  logic       phase_last;
  phase_clk_t clks;

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // synchronous, so it is just the highest-priority branch inside the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= P0;
      div_q   <= '0;
    end else begin
      phase_q <= phase_d;
      div_q   <= div_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    phase_last = (div_q == DIV_LAST);
    div_d      = div_q + 4'd1;
    phase_d    = phase_q;
    if (phase_last) begin
      div_d   = '0;
      phase_d = phase_e'(phase_q + 2'd1);  // 2-bit wrap takes P3 back to P0
    end
  end

  assign clks    = phase_clk(phase_q);
  assign clk_0   = clks.clk_0;
  assign clk_1   = clks.clk_1;
  assign cyc_end = phase_last && (phase_q == P3);
  assign phase   = phase_q;

endmodule

// File: rtl/mcpu_bus_master.sv
// MCPU bus master: turns request/response transactions into continuous
// four-phase E/Q bus cycles, inserting dummy cycles when nothing is pending.
module mcpu_bus_master
  import system86_pkg::*;
#(
  parameter int          PHASE_DIV = 1,
  parameter logic [15:0] IDLE_ADDR = IDLE_ADDR_DEFAULT
) (
  input  logic        CLK_6M,
  input  logic        MRESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [15:0] REQ_ADDR,
  input  logic        REQ_WE,
  input  logic [7:0]  REQ_WDATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic [15:0] MA,
  output logic        nMWE,
  output logic [7:0]  MD_OUT,
  output logic        MD_OE,
  input  logic [7:0]  MD_IN,
  output logic        CLK_0,
  output logic        CLK_1,
  input  logic        nIRQ_IN,
  output logic        IRQ_PEND
);

  typedef struct packed {
    logic        active;  // 0 = dummy cycle
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } bus_cycle_t;

  logic [1:0] phase_raw;
  phase_e     phase;
  logic       cyc_end;
  bus_cycle_t cur_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;
  logic       irq_pend_q;

  mbus_phase_gen #(
    .PHASE_DIV(PHASE_DIV)
  ) u_phase_gen (
    .clk     (CLK_6M),
    .rst     (MRESET),
    .phase   (phase_raw),
    .clk_0   (CLK_0),
    .clk_1   (CLK_1),
    .cyc_end (cyc_end)
  );

  assign phase = phase_e'(phase_raw);

  // The edge ending P3 is the falling edge of E: it samples read data and the
  // interrupt line, retires the current cycle and loads the next one.
  always_ff @(posedge CLK_6M) begin
    if (MRESET) begin
      cur_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      irq_pend_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (cyc_end) begin
        rsp_valid_q <= cur_q.active;
        if (cur_q.active) rsp_rdata_q <= cur_q.we ? 8'h00 : MD_IN;
        irq_pend_q   <= ~nIRQ_IN;
        cur_q.active <= REQ_VALID;
        cur_q.we     <= REQ_VALID & REQ_WE;
        cur_q.addr   <= REQ_VALID ? REQ_ADDR : IDLE_ADDR;
        cur_q.wdata  <= (REQ_VALID & REQ_WE) ? REQ_WDATA : 8'h00;
      end
    end
  end

  assign REQ_READY = cyc_end & ~MRESET;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign IRQ_PEND  = irq_pend_q;
  assign MA        = cur_q.active ? cur_q.addr : IDLE_ADDR;
  assign nMWE      = ~(cur_q.active & cur_q.we);
  assign MD_OUT    = cur_q.wdata;
  // Write data is only driven once the address has settled for a full phase.
  assign MD_OE     = cur_q.active & cur_q.we & (phase != P0);

endmodule

// File: tb/tb_mcpu_bus_master.sv
// Directed self-checking bench for mcpu_bus_master at PHASE_DIV=1 and 3.
module tb_mcpu_bus_master;

  logic        clk = 1'b0;
  logic        mreset, req_valid, req_we, nirq_in;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, md_in;
  logic        req_ready, rsp_valid, nmwe, md_oe, clk_0, clk_1, irq_pend;
  logic [7:0]  rsp_rdata, md_out;
  logic [15:0] ma;

  logic        mreset3, nirq3, req_valid3, req_we3;
  logic [15:0] req_addr3;
  logic [7:0]  req_wdata3, md_in3;
  logic        req_ready3, rsp_valid3, nmwe3, md_oe3, clk_03, clk_13, irq_pend3;
  logic [7:0]  rsp_rdata3, md_out3;
  logic [15:0] ma3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mcpu_bus_master #(.PHASE_DIV(1)) dut (
    .CLK_6M(clk), .MRESET(mreset), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_ADDR(req_addr), .REQ_WE(req_we), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .MA(ma), .nMWE(nmwe),
    .MD_OUT(md_out), .MD_OE(md_oe), .MD_IN(md_in), .CLK_0(clk_0), .CLK_1(clk_1),
    .nIRQ_IN(nirq_in), .IRQ_PEND(irq_pend)
  );

  mcpu_bus_master #(.PHASE_DIV(3)) dut3 (
    .CLK_6M(clk), .MRESET(mreset3), .REQ_VALID(req_valid3), .REQ_READY(req_ready3),
    .REQ_ADDR(req_addr3), .REQ_WE(req_we3), .REQ_WDATA(req_wdata3),
    .RSP_VALID(rsp_valid3), .RSP_RDATA(rsp_rdata3), .MA(ma3), .nMWE(nmwe3),
    .MD_OUT(md_out3), .MD_OE(md_oe3), .MD_IN(md_in3), .CLK_0(clk_03), .CLK_1(clk_13),
    .nIRQ_IN(nirq3), .IRQ_PEND(irq_pend3)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    check("ready_timeout", {15'd0, req_ready}, 16'd1);
  endtask

  initial begin
    logic [15:0] rd_addr [3];
    logic [7:0]  rd_data [3];
    rd_addr = '{16'h1000, 16'h2000, 16'h3000};
    rd_data = '{8'h11, 8'h22, 8'h33};

    mreset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0000;
    req_wdata = 8'h00; md_in = 8'h00; nirq_in = 1'b1;
    mreset3 = 1'b1; nirq3 = 1'b1; req_valid3 = 1'b0; req_we3 = 1'b0;
    req_addr3 = 16'h0000; req_wdata3 = 8'h00; md_in3 = 8'h00;
    repeat (3) tick();

    // reset state
    check("rst_ma", ma, 16'hFFFF);
    check("rst_nmwe", {15'd0, nmwe}, 16'd1);
    check("rst_md_oe", {15'd0, md_oe}, 16'd0);
    check("rst_md_out", {8'd0, md_out}, 16'd0);
    check("rst_clks", {14'd0, clk_1, clk_0}, 16'd0);
    check("rst_ready", {15'd0, req_ready}, 16'd0);
    check("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    check("rst_rsp_rdata", {8'd0, rsp_rdata}, 16'd0);
    check("rst_irq", {15'd0, irq_pend}, 16'd0);

    // idle running: dummy cycles, Q toggles every 2 clocks, E lags by one
    mreset = 1'b0; mreset3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("idle_clk_1", {15'd0, clk_1}, {15'd0, (i % 4 == 1) || (i % 4 == 2)});
      check("idle_clk_0", {15'd0, clk_0}, {15'd0, (i % 4 >= 2)});
      check("idle_ready", {15'd0, req_ready}, {15'd0, (i % 4 == 3)});
      check("idle_ma", ma, 16'hFFFF);
      check("idle_nmwe", {15'd0, nmwe}, 16'd1);
      check("idle_rsp", {15'd0, rsp_valid}, 16'd0);
      tick();
    end

    // single read of 8800
    req_valid = 1'b1; req_addr = 16'h8800; req_we = 1'b0; md_in = 8'h5A;
    wait_ready();
    tick();
    req_valid = 1'b0; req_addr = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      check("rd_ma", ma, 16'h8800);
      check("rd_nmwe", {15'd0, nmwe}, 16'd1);
      check("rd_md_oe", {15'd0, md_oe}, 16'd0);
      check("rd_rsp_early", {15'd0, rsp_valid}, 16'd0);
      tick();
    end
    check("rd_rsp_valid", {15'd0, rsp_valid}, 16'd1);
    check("rd_rdata", {8'd0, rsp_rdata}, 16'h005A);
    check("rd_ma_after", ma, 16'hFFFF);
    md_in = 8'hEE;
    tick();
    check("rd_rsp_pulse", {15'd0, rsp_valid}, 16'd0);
    check("rd_rdata_hold", {8'd0, rsp_rdata}, 16'h005A);

    // single write of C3 to D003; request data changes after acceptance
    req_valid = 1'b1; req_addr = 16'hD003; req_we = 1'b1; req_wdata = 8'hC3;
    wait_ready();
    tick();
    req_valid = 1'b0; req_we = 1'b0; req_wdata = 8'h00;
    for (int k = 0; k < 4; k++) begin
      check("wr_ma", ma, 16'hD003);
      check("wr_nmwe", {15'd0, nmwe}, 16'd0);
      check("wr_md_out", {8'd0, md_out}, 16'h00C3);
      check("wr_md_oe", {15'd0, md_oe}, {15'd0, k != 0});
      check("wr_rsp_early", {15'd0, rsp_valid}, 16'd0);
      tick();
    end
    check("wr_rsp_valid", {15'd0, rsp_valid}, 16'd1);
    check("wr_rdata", {8'd0, rsp_rdata}, 16'h0000);
    check("wr_nmwe_after", {15'd0, nmwe}, 16'd1);
    check("wr_md_oe_after", {15'd0, md_oe}, 16'd0);

    // three back-to-back reads with REQ_VALID held high
    req_valid = 1'b1; req_we = 1'b0; req_addr = rd_addr[0];
    wait_ready();
    tick();
    for (int j = 0; j < 3; j++) begin
      md_in = rd_data[j];
      if (j < 2) req_addr = rd_addr[j + 1];
      else req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        check("b2b_ma", ma, rd_addr[j]);
        if (k == 0 && j > 0) begin
          check("b2b_rsp", {15'd0, rsp_valid}, 16'd1);
          check("b2b_rdata", {8'd0, rsp_rdata}, {8'd0, rd_data[j - 1]});
        end else begin
          check("b2b_no_rsp", {15'd0, rsp_valid}, 16'd0);
        end
        tick();
      end
    end
    check("b2b_rsp_last", {15'd0, rsp_valid}, 16'd1);
    check("b2b_rdata_last", {8'd0, rsp_rdata}, 16'h0033);
    check("b2b_ma_idle", ma, 16'hFFFF);

    // reset pulsed during P2 of a write
    req_valid = 1'b1; req_addr = 16'h4000; req_we = 1'b1; req_wdata = 8'h5C;
    wait_ready();
    tick();
    req_valid = 1'b0; req_we = 1'b0;
    tick();
    tick();
    check("abort_p2_nmwe", {15'd0, nmwe}, 16'd0);
    check("abort_p2_md_oe", {15'd0, md_oe}, 16'd1);
    check("abort_p2_clks", {14'd0, clk_1, clk_0}, 16'b11);
    mreset = 1'b1;
    tick();
    mreset = 1'b0;
    check("abort_nmwe", {15'd0, nmwe}, 16'd1);
    check("abort_md_oe", {15'd0, md_oe}, 16'd0);
    check("abort_clks", {14'd0, clk_1, clk_0}, 16'b00);
    for (int k = 0; k < 5; k++) begin
      check("abort_ma", ma, 16'hFFFF);
      check("abort_no_rsp", {15'd0, rsp_valid}, 16'd0);
      tick();
    end
    check("abort_rdata", {8'd0, rsp_rdata}, 16'h0000);

    // PHASE_DIV=3: phase length and IRQ sampling on the edge ending P3
    mreset3 = 1'b1;
    tick();
    mreset3 = 1'b0;
    for (int s = 0; s < 12; s++) begin
      check("div3_clk_1", {15'd0, clk_13}, {15'd0, (s / 3 == 1) || (s / 3 == 2)});
      check("div3_clk_0", {15'd0, clk_03}, {15'd0, (s / 3 >= 2)});
      check("div3_ready", {15'd0, req_ready3}, {15'd0, s == 11});
      check("div3_irq_wait", {15'd0, irq_pend3}, 16'd0);
      if (s == 4) nirq3 = 1'b0;
      tick();
    end
    check("div3_irq_set", {15'd0, irq_pend3}, 16'd1);
    check("div3_wrap_clks", {14'd0, clk_13, clk_03}, 16'b00);
    nirq3 = 1'b1;
    for (int s = 0; s < 11; s++) tick();
    check("div3_irq_hold", {15'd0, irq_pend3}, 16'd1);
    tick();
    check("div3_irq_clear", {15'd0, irq_pend3}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
